// File: rtl/fpcvt_pkg.sv
// Shared FPCVT types and constants: 8-bit compressed float {S, E[2:0], F[3:0]}.
// FP_TO_TWOS_MIDPOINT_EN adds half-LSB reconstruction bias in fp_mag().
package fpcvt_pkg;

  localparam int DW    = 12;
  localparam int EW    = 3;
  localparam int FW    = 4;
  localparam int MAG_W = 11;
  localparam logic [MAG_W-1:0] MAX_MAG = 11'd1920;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [FW-1:0] sig;
  } fp8_t;

  // F=0 stays exactly zero in both builds, so the bias never creates a value from nothing
  function automatic logic [MAG_W-1:0] fp_mag(input fp8_t f);
    logic [MAG_W-1:0] m;
    m = MAG_W'(f.sig) << f.exp;
`ifdef FP_TO_TWOS_MIDPOINT_EN
    if ((f.exp != '0) && (f.sig != '0))
      m = m + (MAG_W'(1) << (f.exp - 3'd1));
`endif
    return m;
  endfunction

endpackage

// File: rtl/fp_to_twos_if.sv
// Input/output handshake bundle for fp_to_twos; slave = decoder, master = driver/sink.
interface fp_to_twos_if;
  import fpcvt_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [FW-1:0] in_sig;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_neg_zero;

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_data, out_neg_zero
  );

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_data, out_neg_zero
  );

endinterface

// File: rtl/mag_to_twos.sv
// Magnitude + sign to two's complement; zero magnitude with sign set flags neg_zero.
module mag_to_twos
  import fpcvt_pkg::*;
(
  input  logic [MAG_W-1:0] mag_i,
  input  logic             sign_i,
  output logic [DW-1:0]    data_o,
  output logic             neg_zero_o
);

  logic [DW-1:0] ext;

  assign ext = {1'b0, mag_i};
  // ~0 + 1 wraps to 0 in DW bits, so negative zero lands on 12'h000 cleanly
  assign data_o     = sign_i ? (~ext + DW'(1)) : ext;
  assign neg_zero_o = sign_i & (mag_i == '0);

endmodule

// File: rtl/fp_to_twos.sv
// 2-stage compressed-float to 12-bit two's complement decoder with valid/ready.
// Build option FP_TO_TWOS_MIDPOINT_EN enables midpoint (half-LSB) reconstruction.
module fp_to_twos
  import fpcvt_pkg::*;
(
  input logic         clk,
  input logic         rst,
  fp_to_twos_if.slave bus
);

  fp8_t             in_fp;
  logic             in_fire;
  logic             s1_adv;

  logic             s1_valid_q, s1_valid_d;
  logic [MAG_W-1:0] s1_mag_q,   s1_mag_d;
  logic             s1_sign_q,  s1_sign_d;
  logic             s1_negz_q,  s1_negz_d;

  logic             s2_valid_q, s2_valid_d;
  logic [DW-1:0]    s2_data_q,  s2_data_d;
  logic             s2_negz_q,  s2_negz_d;

  logic [DW-1:0]    twos_data;
  logic             twos_negz;

  assign in_fp   = '{sign: bus.in_sign, exp: bus.in_exp, sig: bus.in_sig};
  assign s1_adv  = s1_valid_q & (~s2_valid_q | bus.out_ready);
  assign in_fire = bus.in_valid & bus.in_ready;

  assign bus.in_ready     = ~s1_valid_q | s1_adv;
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_data     = s2_data_q;
  assign bus.out_neg_zero = s2_negz_q;

  mag_to_twos u_mag_to_twos (
    .mag_i      (s1_mag_q),
    .sign_i     (s1_sign_q),
    .data_o     (twos_data),
    .neg_zero_o (twos_negz)
  );

  always_comb begin
    s1_valid_d = in_fire | (s1_valid_q & ~s1_adv);
    s1_mag_d   = s1_mag_q;
    s1_sign_d  = s1_sign_q;
    s1_negz_d  = s1_negz_q;
    if (in_fire) begin
      s1_mag_d  = fp_mag(in_fp);
      s1_sign_d = in_fp.sign;
      s1_negz_d = in_fp.sign & (in_fp.sig == '0);
    end
  end

  // Stage 2 only moves on s1_adv, so a stalled output keeps its data
  always_comb begin
    s2_valid_d = s1_adv | (s2_valid_q & ~bus.out_ready);
    s2_data_d  = s2_data_q;
    s2_negz_d  = s2_negz_q;
    if (s1_adv) begin
      s2_data_d = twos_data;
      s2_negz_d = s1_negz_q | twos_negz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_negz_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_negz_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mag_q   <= s1_mag_d;
      s1_sign_q  <= s1_sign_d;
      s1_negz_q  <= s1_negz_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_negz_q  <= s2_negz_d;
    end
  end

endmodule

// File: tb/tb_fp_to_twos.sv
// Scoreboard bench for fp_to_twos: model results queued on input transfer, checked at output.
module tb_fp_to_twos;
  import fpcvt_pkg::*;

  typedef struct {
    logic [DW-1:0] data;
    logic          negz;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_to_twos_if bus();

  fp_to_twos dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          sb[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            cyc    = 0;
  bit            chk_lat = 1'b0;
  logic [DW-1:0] last_data;
  logic          last_negz;
  int            n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic exp_t model(input logic s, input logic [2:0] e, input logic [3:0] f);
    exp_t r;
    int   m;
    m = int'(f) * (1 << e);
`ifdef FP_TO_TWOS_MIDPOINT_EN
    if (e != 0 && f != 0) m = m + (1 << (e - 1));
`endif
    r.data = s ? DW'(-m) : DW'(m);
    r.negz = s && (f == 0);
    r.cyc  = 0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("out_data", bus.out_data, sb[0].data);
          chk("out_negz", bus.out_neg_zero, sb[0].negz);
          if (bus.out_ready) begin
            if (chk_lat) chk("latency", cyc - sb[0].cyc, 2);
            last_data = bus.out_data;
            last_negz = bus.out_neg_zero;
            n_out++;
            void'(sb.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e = model(bus.in_sign, bus.in_exp, bus.in_sig);
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_sig   = f;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int out0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_sig    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_negz", bus.out_neg_zero, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    chk_lat = 1'b1;
    send(1'b0, 3'd3, 4'd13);
    drain();
`ifdef FP_TO_TWOS_MIDPOINT_EN
    chk("t1_data", last_data, 12'd108);
`else
    chk("t1_data", last_data, 12'd104);
`endif

    send(1'b1, 3'd7, 4'd15);
    drain();
`ifdef FP_TO_TWOS_MIDPOINT_EN
    chk("t2_data", last_data, 12'h840);
`else
    chk("t2_data", last_data, 12'h880);
`endif

    send(1'b1, 3'd5, 4'd0);
    drain();
    chk("t3_data", last_data, 12'h000);
    chk("t3_negz", last_negz, 1);

    // backpressure: 4 beats, output stalled for 3 cycles
    chk_lat = 1'b0;
    out0 = n_out;
    bus.out_ready = 1'b0;
    fork
      begin
        send(1'b0, 3'd1, 4'd9);
        send(1'b1, 3'd2, 4'd7);
        send(1'b0, 3'd6, 4'd15);
        send(1'b1, 3'd0, 4'd1);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - out0, 4);

    // full sweep, streaming one beat per cycle
    chk_lat = 1'b1;
    out0 = n_out;
    t0 = cyc;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] code;
      code = 8'(i);
      send(code[7], code[6:4], code[3:0]);
    end
    chk("sweep_cycles", cyc - t0, 256);
    drain();
    chk("sweep_count", n_out - out0, 256);

    // reset with two beats in flight
    send(1'b0, 3'd4, 4'd3);
    send(1'b1, 3'd2, 4'd5);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    out0 = n_out;
    send(1'b0, 3'd2, 4'd6);
    drain();
    chk("rst_mid_count", n_out - out0, 1);
`ifdef FP_TO_TWOS_MIDPOINT_EN
    chk("rst_mid_data", last_data, 12'd26);
`else
    chk("rst_mid_data", last_data, 12'd24);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
